// File: rtl/nibble_alu_arbiter_pkg.sv
// Shared types and constants for the nibble-serial add/subtract service.
package nibble_alu_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic id_t;

endpackage

// File: rtl/nibble_alu_arbiter_if.sv
// Request/response bundle between two requesters, one consumer and the arbiter.
interface nibble_alu_arbiter_if
    import nibble_alu_pkg::*;
#(
    parameter int NIBBLES = 2
);
    localparam int W = NIBBLE_W * NIBBLES;

    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_sub;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_sub;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;
    logic         rsp_ovf;
    id_t          rsp_id;

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub,
        output req1_valid, req1_a, req1_b, req1_sub,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_sum, rsp_cout, rsp_ovf, rsp_id
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub,
        input  req1_valid, req1_a, req1_b, req1_sub,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_sum, rsp_cout, rsp_ovf, rsp_id
    );

endinterface

// File: rtl/nibble_alu_arbiter_adder.sv
// Combinational 4-bit ripple-carry adder built from per-bit full adders.
module nibble_adder
    import nibble_alu_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    logic [NIBBLE_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_alu_arbiter.sv
// Round-robin arbiter plus nibble-serial add/subtract controller on one shared adder.
module nibble_alu_arbiter
    import nibble_alu_pkg::*;
#(
    parameter int NIBBLES = 2
)(
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_alu_arbiter_if.slave  bus
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int NIB_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [NIB_W-1:0] LAST_NIB = NIB_W'(NIBBLES - 1);

    state_t state;
    state_t state_nxt;

    logic [NIBBLES-1:0][NIBBLE_W-1:0] a_q;
    logic [NIBBLES-1:0][NIBBLE_W-1:0] b_q;
    logic [NIBBLES-1:0][NIBBLE_W-1:0] sum_q;
    logic [NIB_W-1:0]                 nib_q;
    logic                             carry_q;
    logic                             cout_q;
    logic                             ovf_q;
    id_t                              id_q;
    id_t                              last_id_q;

    id_t           grant;
    logic          idle;
    logic          accept;
    logic [W-1:0]  a_sel;
    logic [W-1:0]  b_sel;
    logic          sub_sel;
    logic [NIBBLE_W-1:0] add_s;
    logic          add_cout;
    logic          last_nib;

    // Contention goes to whoever was not served last; otherwise the lone requester.
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid)
            grant = ~last_id_q;
        else
            grant = bus.req1_valid;
    end

    assign idle   = (state == IDLE) && rst_n;
    assign accept = idle && (bus.req0_valid || bus.req1_valid);

    assign bus.req0_ready = idle && bus.req0_valid && (grant == 1'b0);
    assign bus.req1_ready = idle && bus.req1_valid && (grant == 1'b1);

    assign a_sel   = grant ? bus.req1_a   : bus.req0_a;
    assign b_sel   = grant ? bus.req1_b   : bus.req0_b;
    assign sub_sel = grant ? bus.req1_sub : bus.req0_sub;

    assign last_nib = (nib_q == LAST_NIB);

    nibble_adder u_adder (
        .a    (a_q[nib_q]),
        .b    (b_q[nib_q]),
        .cin  (carry_q),
        .s    (add_s),
        .cout (add_cout)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)        state_nxt = EXEC;
            EXEC:    if (last_nib)      state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            nib_q     <= '0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            id_q      <= 1'b0;
            last_id_q <= 1'b1;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Subtraction as A + ~B + 1: invert B here and seed the carry.
                        a_q       <= a_sel;
                        b_q       <= b_sel ^ {W{sub_sel}};
                        carry_q   <= sub_sel;
                        nib_q     <= '0;
                        id_q      <= grant;
                        last_id_q <= grant;
                    end
                end
                EXEC: begin
                    sum_q[nib_q] <= add_s;
                    carry_q      <= add_cout;
                    if (last_nib) begin
                        nib_q  <= '0;
                        cout_q <= add_cout;
                        ovf_q  <= (a_q[NIBBLES-1][NIBBLE_W-1] == b_q[NIBBLES-1][NIBBLE_W-1]) &&
                                  (add_s[NIBBLE_W-1] != a_q[NIBBLES-1][NIBBLE_W-1]);
                    end else begin
                        nib_q <= nib_q + NIB_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_cout  = cout_q;
    assign bus.rsp_ovf   = ovf_q;
    assign bus.rsp_id    = id_q;

endmodule

// File: tb/tb_nibble_alu_arbiter.sv
// Scoreboard bench: arithmetic/arbitration reference model vs. nibble_alu_arbiter.
module tb_nibble_alu_arbiter;
    import nibble_alu_pkg::*;

    localparam int N = 2;
    localparam int W = 4 * N;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         id;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   rr_mode = 0;

    exp_t q[$];
    logic id_log[$];
    bit   log_en = 0;
    bit   busy = 0;
    bit   m_last = 1;
    int   acc_cyc = 0;
    bit   rst_prev = 1;

    nibble_alu_arbiter_if #(.NIBBLES(N)) bus ();

    nibble_alu_arbiter #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (rr_mode)
            1:       bus.rsp_ready = 1'b0;
            2:       bus.rsp_ready = 1'($urandom_range(0, 1));
            default: bus.rsp_ready = 1'b1;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the unsigned and signed views of the operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input bit s, input bit id);
        exp_t e;
        int ua = int'(a);
        int ub = int'(b);
        int sa = a[W-1] ? ua - (1 << W) : ua;
        int sb = b[W-1] ? ub - (1 << W) : ub;
        int r  = s ? ua - ub : ua + ub;
        int sr = s ? sa - sb : sa + sb;
        e.sum  = W'(r);
        e.cout = s ? (ua >= ub) : ((ua + ub) >= (1 << W));
        e.ovf  = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
        e.id   = id;
        return e;
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        bit g, e0, e1, ev;
        if (!rst_n) begin
            chk("ready0_in_reset", 32'(bus.req0_ready), 0);
            chk("ready1_in_reset", 32'(bus.req1_ready), 0);
            if (!rst_prev) begin
                chk("rsp_valid_reset", 32'(bus.rsp_valid), 0);
                chk("rsp_sum_reset",   32'(bus.rsp_sum),   0);
                chk("rsp_cout_reset",  32'(bus.rsp_cout),  0);
                chk("rsp_ovf_reset",   32'(bus.rsp_ovf),   0);
                chk("rsp_id_reset",    32'(bus.rsp_id),    0);
            end
            busy = 0;
            q.delete();
            m_last = 1;
        end else begin
            g  = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
            e0 = !busy && bus.req0_valid && !g;
            e1 = !busy && bus.req1_valid && g;
            chk("req0_ready", 32'(bus.req0_ready), 32'(e0));
            chk("req1_ready", 32'(bus.req1_ready), 32'(e1));
            ev = busy && (cyc >= acc_cyc + N);
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
            if (bus.rsp_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 expected no pending op (cycle %0d)", cyc);
                end else begin
                    e = q[0];
                    chk("rsp_sum",  32'(bus.rsp_sum),  32'(e.sum));
                    chk("rsp_cout", 32'(bus.rsp_cout), 32'(e.cout));
                    chk("rsp_ovf",  32'(bus.rsp_ovf),  32'(e.ovf));
                    chk("rsp_id",   32'(bus.rsp_id),   32'(e.id));
                    if (bus.rsp_ready) begin
                        void'(q.pop_front());
                        busy = 0;
                        if (log_en) id_log.push_back(bus.rsp_id);
                    end
                end
            end
            if (e0 || e1) begin
                if (g) q.push_back(model(bus.req1_a, bus.req1_b, bus.req1_sub, 1'b1));
                else   q.push_back(model(bus.req0_a, bus.req0_b, bus.req0_sub, 1'b0));
                busy    = 1;
                acc_cyc = cyc + 1;
                m_last  = g;
            end
        end
        rst_prev = rst_n;
    end

    task automatic send(input bit r, input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
        int n = 0;
        if (r) begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_sub = s; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_sub = s; bus.req0_valid = 1'b1;
        end
        do begin
            @(negedge clk);
            n++;
        end while (!(r ? bus.req1_ready : bus.req0_ready) && n < 300);
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: requester %0d got no ready, expected ready within 300 cycles", r);
        end
        @(posedge clk);
        #1;
        if (r) bus.req1_valid = 1'b0;
        else   bus.req0_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || q.size() != 0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending ops expected 0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_loop(input bit r, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            send(r, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sub = 0;
        bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sub = 0;
        bus.rsp_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(0, 8'h3C, 8'h15, 0);
        send(1, 8'h10, 8'h01, 1);
        send(1, 8'h01, 8'h02, 1);
        send(1, 8'h80, 8'h01, 1);
        send(0, 8'h7F, 8'h01, 0);
        send(1, 8'hFF, 8'h01, 0);
        drain();

        // Both requesters continuously valid: responses must alternate 0,1,0,1.
        log_en = 1;
        fork
            begin send(0, 8'h11, 8'h22, 0); send(0, 8'h33, 8'h44, 1); end
            begin send(1, 8'h55, 8'h66, 0); send(1, 8'hA0, 8'h0B, 1); end
        join
        drain();
        log_en = 0;
        chk("fair_count", 32'(id_log.size()), 4);
        for (int i = 0; i < id_log.size() && i < 4; i++)
            chk("fair_order", 32'(id_log[i]), 32'(i % 2));
        id_log.delete();

        rr_mode = 1;
        fork
            send(0, 8'hC3, 8'h5A, 1);
            send(1, 8'h0F, 8'hF1, 0);
        join_none
        repeat (12) @(posedge clk);
        rr_mode = 0;
        wait fork;
        drain();

        // Reset while the shared adder is mid-operation.
        send(1, 8'h12, 8'h34, 0);
        rst_n = 1'b0;
        bus.req0_a = 8'h40; bus.req0_b = 8'h40; bus.req0_sub = 0; bus.req0_valid = 1;
        bus.req1_a = 8'h05; bus.req1_b = 8'h09; bus.req1_sub = 1; bus.req1_valid = 1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        log_en = 1;
        fork
            send(0, 8'h40, 8'h40, 0);
            send(1, 8'h05, 8'h09, 1);
        join
        drain();
        log_en = 0;
        chk("post_reset_count", 32'(id_log.size()), 2);
        if (id_log.size() > 0)
            chk("post_reset_first", 32'(id_log[0]), 0);
        id_log.delete();

        rr_mode = 2;
        fork
            rand_loop(0, 15);
            rand_loop(1, 15);
        join
        rr_mode = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_alu_arbiter.md
# nibble_alu_arbiter

Two-requester add/subtract service built on a single shared 4-bit ripple-carry adder. A round-robin arbiter grants one requester at a time. The controller then runs the W-bit operation through the adder one nibble per cycle, least-significant nibble first, and chains the carry in a register. The result goes out on a valid/ready response port tagged with the requester id.

## Interface
- NIBBLES, default 2: operand width in nibbles; W = 4*NIBBLES; must be >= 1.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- req0_valid  in  1  requester 0 holds an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  W  operands
- req0_sub  in  1  1 = A−B, 0 = A+B
- req1_valid, req1_ready, req1_a, req1_b, req1_sub: same meaning, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_sum  out  W  result, mod 2^W
- rsp_cout  out  1  carry out of bit W−1 (for sub: 1 = no borrow, A >= B unsigned)
- rsp_ovf  out  1  signed two's-complement overflow
- rsp_id  out  1  requester that issued the result

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Grant one valid requester.
  - If both are valid, grant the one not granted last. A last_id register holds this; it resets to 1, so req0 wins first.
  - reqN_ready = (state==IDLE) & reqN_valid & (grant==N). It may depend combinationally on valid.
  - On handshake, latch a, b^{W{sub}}, sub and id. Set carry = sub, nib = 0, last_id = id, and move to EXEC.
  - If neither requester is valid, stay in IDLE.
- **EXEC**
  - Each cycle, drive the adder with a[nib], b'[nib] and carry.
  - Write the adder sum into sum[nib], set carry ← adder cout, and nib++.
  - After nib = NIBBLES−1: set cout ← adder cout, compute ovf, and move to RESP.
  - The adder is always used in add mode. Subtraction is done by the controller: it pre-inverts B and seeds the initial carry with 1. Subtraction handling inside the adder is not used.
- **RESP**
  - rsp_valid = 1. All rsp_* fields are stable until handshake.
  - On rsp_valid & rsp_ready, move to IDLE.
  - Both req*_ready are 0 in EXEC and RESP.
- Overflow: ovf = (a[W−1] == b'[W−1]) & (sum[W−1] != a[W−1]).
- Requesters must hold valid and operands stable until ready. A requester may drop valid before it is granted; it is simply not granted.

## Timing
- Reset, synchronous, rst_n = 0 at an edge:
  - state is IDLE, rsp_valid = 0, rsp_sum / rsp_cout / rsp_ovf / rsp_id = 0.
  - Both req*_ready = 0 while rst_n is low.
  - last_id = 1, nib = 0, carry = 0.
- Reset mid-operation: the in-flight operation is dropped and no response is issued.
- Latency: for an accept at edge k, rsp_valid is high after edge k+NIBBLES. For the default 2, rsp_valid is seen on the second edge after accept.
- Throughput: at most one operation per NIBBLES+2 cycles with rsp_ready tied high, because RESP returns to IDLE before the next grant.
- Response handshake and new request arrival in the same cycle: the new request waits in IDLE for the next cycle.
- rsp_ready held low: the block stalls in RESP indefinitely, and both requesters are back-pressured.

## Structure
- Shared package nibble_alu_pkg holds:
  - the state enum (IDLE/EXEC/RESP)
  - the NIBBLE_W = 4 constant
  - the id type (1 bit)
- One sub-module, nibble_adder: a combinational 4-bit ripple-carry adder with explicit cin and cout (a, b, cin, s, cout), built from 1-bit full adders.
- The arbiter, FSM, operand registers and nibble mux live in nibble_alu_arbiter.

## Test plan
- **Basic add:** after reset, req0 add A=0x3C B=0x15 → rsp_sum=0x51, cout=0, ovf=0, id=0; rsp_valid exactly 2 edges after accept.
- **Subtract:**
  - req1 sub 0x10−0x01 → 0x0F, cout=1, ovf=0, id=1.
  - 0x01−0x02 → 0xFF, cout=0, ovf=0.
  - 0x80−0x01 → 0x7F, ovf=1.
- **Carry/overflow edges:**
  - add 0x7F+0x01 → 0x80, ovf=1, cout=0.
  - add 0xFF+0x01 → 0x00, cout=1, ovf=0. This checks the inter-nibble carry.
- **Fairness:** req0 and req1 both valid continuously with distinct operands → rsp_id sequence 0,1,0,1; each ready pulses once per grant.
- **Back-pressure:** rsp_ready low for 5 cycles in RESP → rsp_* fields unchanged, both req*_ready stay 0. rsp_ready high → handshake, and the next grant comes the following cycle.
- **Reset mid-operation:** assert rst_n=0 during EXEC → no rsp_valid, all outputs 0. After release, with both valid, req0 is granted first.
